// File: rtl/ether_frame_rx_pkg.sv
// Shared definitions for the ether_frame_rx serial frame receiver.
//  - Frame geometry: SEQ_LEN bits, MSB (bit 57) on the line first.
//  - Fixed-field values and bit positions of header, separators, payload and trailer.
//  - Error codes reported on err_code_out and the receiver FSM state encoding.
//  - frame_check(): classifies a captured frame (header > separator > trailer priority).
package ether_frame_rx_pkg;

    localparam int unsigned BIT_DIV_DEFAULT = 320;
    localparam int unsigned SEQ_LEN         = 58;
    localparam int unsigned FIELD_W         = 16;
    localparam int unsigned CNT_W           = 6;

    // Header spans [57:41]: 000, 11, then twelve zeros.
    localparam int unsigned HDR_W         = 17;
    localparam logic [16:0] HDR_VALUE     = 17'b000_11_0000_0000_0000;
    localparam int unsigned SEP_A_LSB     = 39;
    localparam int unsigned SEP_B_LSB     = 21;
    localparam logic [1:0]  SEP_VALUE     = 2'b11;
    localparam int unsigned FIELD_A_LSB   = 23;
    localparam int unsigned FIELD_B_LSB   = 5;
    localparam logic [4:0]  TRAILER_VALUE = 5'b11000;

    typedef enum logic [1:0] {
        ErrNone      = 2'b00,
        ErrHeader    = 2'b01,
        ErrSeparator = 2'b10,
        ErrTrailer   = 2'b11
    } err_code_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StCheck,
        StWaitIdle
    } rx_state_e;

    function automatic err_code_e frame_check(input logic [SEQ_LEN-1:0] frame);
        if (frame[SEQ_LEN-1 -: HDR_W] != HDR_VALUE) begin
            return ErrHeader;
        end
        if ((frame[SEP_A_LSB +: 2] != SEP_VALUE) || (frame[SEP_B_LSB +: 2] != SEP_VALUE)) begin
            return ErrSeparator;
        end
        if (frame[4:0] != TRAILER_VALUE) begin
            return ErrTrailer;
        end
        return ErrNone;
    endfunction

endpackage

// File: rtl/ether_frame_rx_bit_timer.sv
// Loadable down-counter with a one-cycle expire strobe.
//  clk_in       in   system clock
//  reset_in     in   asynchronous active-low reset
//  load_in      in   load load_val_in and start running (wins over expiry)
//  load_val_in  in   start value; expire_out fires load_val_in+1 cycles after the load
//  expire_out   out  high for one cycle when a running count reaches zero
module ether_frame_rx_bit_timer #(
    parameter int unsigned BIT_DIV = 320,
    localparam int unsigned TMR_W  = $clog2(BIT_DIV)
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             load_in,
    input  logic [TMR_W-1:0] load_val_in,
    output logic             expire_out
);

    logic [TMR_W-1:0] cnt_q;
    logic             run_q;

    assign expire_out = run_q && (cnt_q == '0);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_in) begin
            cnt_q <= load_val_in;
            run_q <= 1'b1;
        end else if (expire_out) begin
            // Stop after expiry; the FSM reloads when it wants another period.
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/ether_frame_rx.sv
// Serial frame receiver for the idle-high ether pulse line.
// Samples the line mid-bit with an internal bit timer, captures a 58-bit frame
// (MSB first), validates header/separator/trailer and presents the two payload fields.
//  clk_in          in   system clock
//  reset_in        in   asynchronous active-low reset
//  ether_pulse_in  in   serial line, idle 1, asynchronous to clk_in
//  busy_out        out  low only while waiting for a start edge
//  frame_valid_out out  1-cycle strobe, frame accepted and fields updated
//  frame_err_out   out  1-cycle strobe, frame rejected
//  err_code_out    out  00 none, 01 header, 10 separator, 11 trailer
//  field_a_out     out  frame bits [38:23]
//  field_b_out     out  frame bits [20:5]
module ether_frame_rx
    import ether_frame_rx_pkg::*;
#(
    parameter int unsigned BIT_DIV = BIT_DIV_DEFAULT
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               ether_pulse_in,
    output logic               busy_out,
    output logic               frame_valid_out,
    output logic               frame_err_out,
    output logic [1:0]         err_code_out,
    output logic [FIELD_W-1:0] field_a_out,
    output logic [FIELD_W-1:0] field_b_out
);

    localparam int unsigned      TMR_W     = $clog2(BIT_DIV);
    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BIT_DIV / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(SEQ_LEN - 1);

    logic               sync1_q;
    logic               sync2_q;
    logic               line_d_q;
    logic               line;
    logic               line_fall;

    rx_state_e          state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [SEQ_LEN-1:0] shreg_q;
    err_code_e          frame_status;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_expire;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            line_d_q <= 1'b0;
        end else begin
            sync1_q  <= ether_pulse_in;
            sync2_q  <= sync1_q;
            line_d_q <= sync2_q;
        end
    end

    assign line         = sync2_q;
    assign line_fall    = line_d_q && !line;
    assign frame_status = frame_check(shreg_q);

    // Timer control: half a bit to reach mid-bit, then whole bits; in WAIT_IDLE
    // every low sample restarts the one-bit-long idle qualification.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = FULL_LOAD;
        case (state_q)
            StIdle: begin
                if (line_fall) begin
                    tmr_load = 1'b1;
                    tmr_val  = HALF_LOAD;
                end
            end
            StStart: begin
                tmr_load = tmr_expire && !line;
            end
            StShift: begin
                tmr_load = tmr_expire && (bit_cnt_q != LAST_BIT);
            end
            StCheck: begin
                tmr_load = 1'b1;
            end
            StWaitIdle: begin
                tmr_load = !line;
            end
            default: begin
                tmr_load = 1'b0;
            end
        endcase
    end

    ether_frame_rx_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_bit_timer (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .load_in     (tmr_load),
        .load_val_in (tmr_val),
        .expire_out  (tmr_expire)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            shreg_q         <= '0;
            busy_out        <= 1'b0;
            frame_valid_out <= 1'b0;
            frame_err_out   <= 1'b0;
            err_code_out    <= ErrNone;
            field_a_out     <= '0;
            field_b_out     <= '0;
        end else begin
            frame_valid_out <= 1'b0;
            frame_err_out   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (line_fall) begin
                        state_q  <= StStart;
                        busy_out <= 1'b1;
                    end
                end
                StStart: begin
                    if (tmr_expire) begin
                        if (line) begin
                            // Glitch shorter than half a bit: drop it silently.
                            state_q  <= StIdle;
                            busy_out <= 1'b0;
                        end else begin
                            shreg_q   <= {shreg_q[SEQ_LEN-2:0], line};
                            bit_cnt_q <= CNT_W'(1);
                            state_q   <= StShift;
                        end
                    end
                end
                StShift: begin
                    if (tmr_expire) begin
                        shreg_q   <= {shreg_q[SEQ_LEN-2:0], line};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    state_q      <= StWaitIdle;
                    err_code_out <= frame_status;
                    if (frame_status == ErrNone) begin
                        field_a_out     <= shreg_q[FIELD_A_LSB +: FIELD_W];
                        field_b_out     <= shreg_q[FIELD_B_LSB +: FIELD_W];
                        frame_valid_out <= 1'b1;
                    end else begin
                        frame_err_out <= 1'b1;
                    end
                end
                StWaitIdle: begin
                    // A low sample reloads the timer, so expiry implies a full idle bit.
                    if (tmr_expire && line) begin
                        state_q  <= StIdle;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ether_frame_rx.sv
module tb_ether_frame_rx;

    localparam int BIT_DIV = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line;
    logic        busy;
    logic        fvalid;
    logic        ferr;
    logic [1:0]  code;
    logic [15:0] fa;
    logic [15:0] fb;

    always #5 clk = ~clk;

    ether_frame_rx #(
        .BIT_DIV (BIT_DIV)
    ) dut (
        .clk_in          (clk),
        .reset_in        (rst_n),
        .ether_pulse_in  (line),
        .busy_out        (busy),
        .frame_valid_out (fvalid),
        .frame_err_out   (ferr),
        .err_code_out    (code),
        .field_a_out     (fa),
        .field_b_out     (fb)
    );

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;

    typedef struct packed {
        logic        is_valid;
        logic [1:0]  code;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cur_a = 16'h0;
    logic [15:0] cur_b = 16'h0;
    logic [1:0]  cur_err = 2'b00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Frame image from the payload fields, bit 57 first on the wire.
    function automatic logic [57:0] build_frame(input logic [15:0] a, input logic [15:0] b);
        logic [57:0] f;
        f = '0;
        f[54:53] = 2'b11;
        f[40:39] = 2'b11;
        f[38:23] = a;
        f[22:21] = 2'b11;
        f[20:5]  = b;
        f[4:0]   = 5'b11000;
        return f;
    endfunction

    function automatic logic [1:0] model_code(input logic [57:0] f);
        if (f[57:41] != {3'b000, 2'b11, 12'h000}) return 2'b01;
        if (!(f[40:39] == 2'b11 && f[22:21] == 2'b11)) return 2'b10;
        if (f[4:0] != 5'b11000) return 2'b11;
        return 2'b00;
    endfunction

    function automatic exp_t predict(input logic [57:0] f);
        exp_t e;
        e.code     = model_code(f);
        e.is_valid = (e.code == 2'b00);
        e.a        = f[38:23];
        e.b        = f[20:5];
        return e;
    endfunction

    // Scoreboard: every strobe consumes one expectation; fields/code always track the model.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!rst_n) begin
            check("reset_outputs", 64'({busy, fvalid, ferr, code, fa, fb}), 64'd0);
            exp_q.delete();
            cur_a   = 16'h0;
            cur_b   = 16'h0;
            cur_err = 2'b00;
        end else begin
            if (fvalid) n_valid++;
            if (ferr) n_err++;
            if (fvalid || ferr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 64'({fvalid, ferr}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 64'({fvalid, ferr}), e.is_valid ? 64'd2 : 64'd1);
                    if (e.is_valid) begin
                        cur_a = e.a;
                        cur_b = e.b;
                    end
                    cur_err = e.code;
                end
            end
            check("fields_code", 64'({fa, fb, code}), 64'({cur_a, cur_b, cur_err}));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [57:0] f, input int n);
        for (int i = 57; i > 57 - n; i--) begin
            line = f[i];
            cycles(BIT_DIV);
        end
    endtask

    // Leaves the line at the last frame bit (0); callers decide what follows.
    task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [57:0] flip);
        logic [57:0] f;
        f = build_frame(a, b) ^ flip;
        exp_q.push_back(predict(f));
        send_bits(f, 58);
    endtask

    task automatic idle_bits(input int n);
        line = 1'b1;
        cycles(n * BIT_DIV);
    endtask

    int v0;
    int e0;

    initial begin
        rst_n = 1'b0;
        line  = 1'b1;
        cycles(3);
        check("reset_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        cycles(4);

        // Model pinned against hand-built frame images and error codes.
        check("model_frame_000F_0000", 64'(build_frame(16'h000F, 16'h0000)),
              64'h0060018007E00018);
        check("model_frame_0003_FFFC", 64'(build_frame(16'h0003, 16'hFFFC)),
              64'h0060018001FFFF98);
        check("model_code_sep", 64'(model_code(build_frame(16'h1, 16'h2) ^ (58'd1 << 40))), 64'd2);
        check("model_code_trl", 64'(model_code(build_frame(16'h1, 16'h2) ^ (58'd1 << 2))), 64'd3);
        check("model_code_hdr", 64'(model_code(build_frame(16'h1, 16'h2) ^ (58'd1 << 56))), 64'd1);

        // 1: single good frame
        v0 = n_valid;
        send_frame(16'h000F, 16'h0000, '0);
        idle_bits(3);
        check("t1_valid_count", 64'(n_valid - v0), 64'd1);
        check("t1_fields", 64'({fa, fb, code}), 64'({16'h000F, 16'h0000, 2'b00}));
        check("t1_busy_idle", 64'(busy), 64'd0);

        // 2: two frames separated by two idle bits
        v0 = n_valid;
        send_frame(16'h0003, 16'hFFFC, '0);
        idle_bits(2);
        send_frame(16'h0003, 16'hFFC3, '0);
        idle_bits(3);
        check("t2_valid_count", 64'(n_valid - v0), 64'd2);
        check("t2_fields", 64'({fa, fb}), 64'({16'h0003, 16'hFFC3}));

        // 3: two-cycle glitch is a false start
        v0 = n_valid;
        e0 = n_err;
        line = 1'b0;
        cycles(2);
        line = 1'b1;
        cycles(2);
        check("t3_busy_start", 64'(busy), 64'd1);
        cycles(6);
        check("t3_busy_back", 64'(busy), 64'd0);
        idle_bits(2);
        check("t3_no_strobe", 64'((n_valid - v0) + (n_err - e0)), 64'd0);

        // 4: separator then trailer errors; fields hold
        e0 = n_err;
        send_frame(16'h1234, 16'h5678, 58'd1 << 40);
        idle_bits(3);
        check("t4_sep_code", 64'({code, fa, fb}), 64'({2'b10, 16'h0003, 16'hFFC3}));
        send_frame(16'h1234, 16'h5678, 58'd1 << 2);
        idle_bits(3);
        check("t4_trl_code", 64'({code, fa, fb}), 64'({2'b11, 16'h0003, 16'hFFC3}));
        check("t4_err_count", 64'(n_err - e0), 64'd2);

        // 5: reset at bit 30, then a good frame
        v0 = n_valid;
        e0 = n_err;
        exp_q.push_back(predict(build_frame(16'hABCD, 16'h1234)));
        send_bits(build_frame(16'hABCD, 16'h1234), 30);
        check("t5_busy_mid", 64'(busy), 64'd1);
        rst_n = 1'b0;
        line  = 1'b1;
        cycles(4);
        rst_n = 1'b1;
        idle_bits(3);
        check("t5_after_reset", 64'({busy, code, fa, fb}), 64'd0);
        send_frame(16'hABCD, 16'h1234, '0);
        idle_bits(3);
        check("t5_valid_count", 64'(n_valid - v0), 64'd1);
        check("t5_err_count", 64'(n_err - e0), 64'd0);
        check("t5_fields", 64'({fa, fb}), 64'({16'hABCD, 16'h1234}));

        // 6: line held low 20 bits after a frame
        v0 = n_valid;
        send_frame(16'h5555, 16'hAAAA, '0);
        line = 1'b0;
        cycles(20 * BIT_DIV);
        check("t6_busy_low", 64'(busy), 64'd1);
        check("t6_valid_count", 64'(n_valid - v0), 64'd1);
        line = 1'b1;
        cycles(BIT_DIV);
        check("t6_busy_still", 64'(busy), 64'd1);
        cycles(3);
        check("t6_busy_drop", 64'(busy), 64'd0);
        check("t6_fields", 64'({fa, fb}), 64'({16'h5555, 16'hAAAA}));

        idle_bits(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
